// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS control FSM (master)
// and the datapath it steers (slave).
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUOperation;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtSel;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       Illegal;

  modport master (
    input  Opcode, Funct, Zero,
    output ALUOperation, ALUSrcA, ALUSrcB, ExtSel, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Illegal
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  ALUOperation, ALUSrcA, ALUSrcB, ExtSel, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU operation, datapath selects and write enables.
module multicycle_control #(
  parameter bit ILLEGAL_HOLD = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_ALUWB, S_ITYPE_EX, S_ITYPE_WB, S_BEQ, S_BNE, S_JUMP, S_ILLEGAL
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state_q, state_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic       ext_sel_q, ext_sel_d;
  logic       iord_q, iord_d;
  logic       mem_write_q, mem_write_d;
  logic       ir_write_q, ir_write_d;
  logic       reg_dst_q, reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_write_q, reg_write_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       pc_write_q, pc_write_d;
  logic       branch_q, branch_d;
  logic       branch_ne_q, branch_ne_d;
  logic       illegal_q, illegal_d;
  logic       funct_ok;
  logic [3:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.Funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h27:   funct_alu = ALU_NOR;
      6'h00:   funct_alu = ALU_SLL;
      6'h02:   funct_alu = ALU_SRL;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_RTYPE:                         state_d = funct_ok ? S_RTYPE_EX : S_ILLEGAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_ITYPE_EX;
          OP_BEQ:                           state_d = S_BEQ;
          OP_BNE:                           state_d = S_BNE;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_ALUWB;
      S_ITYPE_EX: state_d = S_ITYPE_WB;
      S_ILLEGAL:  state_d = ILLEGAL_HOLD ? S_ILLEGAL : S_FETCH;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ITYPE_WB, S_BEQ, S_BNE, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    // and remain pure functions of the current state.
    alu_op_d     = ALU_ADD;
    src_a_d      = 1'b0;
    src_b_d      = 2'b00;
    ext_sel_d    = 1'b0;
    iord_d       = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    pc_src_d     = 2'b00;
    pc_write_d   = 1'b0;
    branch_d     = 1'b0;
    branch_ne_d  = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        src_b_d    = 2'b01;
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
      end
      S_DECODE: src_b_d = 2'b11;
      S_MEMADR: begin
        src_a_d = 1'b1;
        src_b_d = 2'b10;
      end
      S_MEMRD:  iord_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      S_MEMWR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      S_RTYPE_EX: begin
        src_a_d  = 1'b1;
        alu_op_d = funct_alu;
      end
      S_ALUWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      S_ITYPE_EX: begin
        src_a_d = 1'b1;
        src_b_d = 2'b10;
        case (bus.Opcode)
          OP_ANDI: begin alu_op_d = ALU_AND; ext_sel_d = 1'b1; end
          OP_ORI:  begin alu_op_d = ALU_OR;  ext_sel_d = 1'b1; end
          OP_LUI:  begin alu_op_d = ALU_LUI; ext_sel_d = 1'b1; end
          default: alu_op_d = ALU_ADD;
        endcase
      end
      S_ITYPE_WB: reg_write_d = 1'b1;
      S_BEQ, S_BNE: begin
        src_a_d     = 1'b1;
        alu_op_d    = ALU_SUB;
        pc_src_d    = 2'b01;
        branch_d    = (state_d == S_BEQ);
        branch_ne_d = (state_d == S_BNE);
      end
      S_JUMP: begin
        pc_src_d   = 2'b10;
        pc_write_d = 1'b1;
      end
      S_ILLEGAL: illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RESET;
      alu_op_q     <= ALU_ADD;
      src_a_q      <= 1'b0;
      src_b_q      <= '0;
      ext_sel_q    <= 1'b0;
      iord_q       <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_src_q     <= '0;
      pc_write_q   <= 1'b0;
      branch_q     <= 1'b0;
      branch_ne_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      ext_sel_q    <= ext_sel_d;
      iord_q       <= iord_d;
      mem_write_q  <= mem_write_d;
      ir_write_q   <= ir_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      pc_src_q     <= pc_src_d;
      pc_write_q   <= pc_write_d;
      branch_q     <= branch_d;
      branch_ne_q  <= branch_ne_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.ALUOperation = alu_op_q;
  assign bus.ALUSrcA      = src_a_q;
  assign bus.ALUSrcB      = src_b_q;
  assign bus.ExtSel       = ext_sel_q;
  assign bus.IorD         = iord_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.IRWrite      = ir_write_q;
  assign bus.RegDst       = reg_dst_q;
  assign bus.MemtoReg     = mem_to_reg_q;
  assign bus.RegWrite     = reg_write_q;
  assign bus.PCSrc        = pc_src_q;
  assign bus.Illegal      = illegal_q;
  assign bus.PCEn         = pc_write_q | (branch_q & bus.Zero) | (branch_ne_q & ~bus.Zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised instruction stream against a per-instruction trace model, run on
// one controller with ILLEGAL_HOLD=0 and one with ILLEGAL_HOLD=1.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       ext, iord, memw, irw, regdst, memtoreg, regw;
    logic [1:0] pcsrc;
    logic       pcwrite, branch, bne, illegal;
  } step_t;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       ext, iord, memw, irw, regdst, memtoreg, regw;
    logic [1:0] pcsrc;
    logic       pcen, illegal;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  multicycle_control #(.ILLEGAL_HOLD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multicycle_control #(.ILLEGAL_HOLD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  obs_t act0, act1;
  always_comb begin
    act0.alu = bus0.ALUOperation; act0.srca = bus0.ALUSrcA; act0.srcb = bus0.ALUSrcB;
    act0.ext = bus0.ExtSel; act0.iord = bus0.IorD; act0.memw = bus0.MemWrite;
    act0.irw = bus0.IRWrite; act0.regdst = bus0.RegDst; act0.memtoreg = bus0.MemtoReg;
    act0.regw = bus0.RegWrite; act0.pcsrc = bus0.PCSrc; act0.pcen = bus0.PCEn;
    act0.illegal = bus0.Illegal;
  end
  always_comb begin
    act1.alu = bus1.ALUOperation; act1.srca = bus1.ALUSrcA; act1.srcb = bus1.ALUSrcB;
    act1.ext = bus1.ExtSel; act1.iord = bus1.IorD; act1.memw = bus1.MemWrite;
    act1.irw = bus1.IRWrite; act1.regdst = bus1.RegDst; act1.memtoreg = bus1.MemtoReg;
    act1.regw = bus1.RegWrite; act1.pcsrc = bus1.PCSrc; act1.pcen = bus1.PCEn;
    act1.illegal = bus1.Illegal;
  end

  int tests = 0;
  int fails = 0;
  step_t trace[$];
  logic [5:0] cur_op, cur_fn;
  logic z;
  int step;
  bit stuck, lw_reset_done, first_fetch;

  function automatic step_t blank();
    step_t s;
    s = '0;
    s.alu = 4'b0011;
    return s;
  endfunction

  // {valid, alu code} for an R-type funct field
  function automatic logic [4:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return {1'b1, 4'b0011};
      6'h22: return {1'b1, 4'b0100};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h27: return {1'b1, 4'b0010};
      6'h00: return {1'b1, 4'b0101};
      6'h02: return {1'b1, 4'b0110};
      default: return 5'b0;
    endcase
  endfunction

  function automatic obs_t expect_obs(input step_t s, input logic zf);
    obs_t o;
    o.alu = s.alu; o.srca = s.srca; o.srcb = s.srcb; o.ext = s.ext; o.iord = s.iord;
    o.memw = s.memw; o.irw = s.irw; o.regdst = s.regdst; o.memtoreg = s.memtoreg;
    o.regw = s.regw; o.pcsrc = s.pcsrc; o.illegal = s.illegal;
    o.pcen = s.pcwrite | (s.branch & zf) | (s.bne & ~zf);
    return o;
  endfunction

  // Appends the cycle-by-cycle output trace of one whole instruction.
  task automatic build_trace(input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    logic [4:0] r;
    s = blank(); s.srcb = 2'b01; s.irw = 1'b1; s.pcwrite = 1'b1; trace.push_back(s);
    s = blank(); s.srcb = 2'b11; trace.push_back(s);
    r = rtype_alu(fn);
    if (op == 6'h23 || op == 6'h2B) begin
      s = blank(); s.srca = 1'b1; s.srcb = 2'b10; trace.push_back(s);
      s = blank(); s.iord = 1'b1; s.memw = (op == 6'h2B); trace.push_back(s);
      if (op == 6'h23) begin
        s = blank(); s.memtoreg = 1'b1; s.regw = 1'b1; trace.push_back(s);
      end
    end else if (op == 6'h00 && r[4]) begin
      s = blank(); s.srca = 1'b1; s.alu = r[3:0]; trace.push_back(s);
      s = blank(); s.regdst = 1'b1; s.regw = 1'b1; trace.push_back(s);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
      s = blank(); s.srca = 1'b1; s.srcb = 2'b10;
      s.ext = (op != 6'h08);
      s.alu = (op == 6'h08) ? 4'b0011 : (op == 6'h0C) ? 4'b0000 :
              (op == 6'h0D) ? 4'b0001 : 4'b0111;
      trace.push_back(s);
      s = blank(); s.regw = 1'b1; trace.push_back(s);
    end else if (op == 6'h04 || op == 6'h05) begin
      s = blank(); s.srca = 1'b1; s.alu = 4'b0100; s.pcsrc = 2'b01;
      s.branch = (op == 6'h04); s.bne = (op == 6'h05); trace.push_back(s);
    end else if (op == 6'h02) begin
      s = blank(); s.pcsrc = 2'b10; s.pcwrite = 1'b1; trace.push_back(s);
    end else begin
      s = blank(); s.illegal = 1'b1; trace.push_back(s);
    end
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic zf);
    bus0.Opcode = op; bus0.Funct = fn; bus0.Zero = zf;
    bus1.Opcode = op; bus1.Funct = fn; bus1.Zero = zf;
  endtask

  task automatic pick_instr();
    logic [5:0] rtype_fns [7];
    rtype_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
    cur_fn = 6'($urandom);
    case ($urandom_range(0, 15))
      0:       cur_op = 6'h23;
      1:       cur_op = 6'h2B;
      2, 3, 4: begin cur_op = 6'h00; cur_fn = rtype_fns[$urandom_range(0, 6)]; end
      5:       cur_op = 6'h08;
      6:       cur_op = 6'h0C;
      7:       cur_op = 6'h0D;
      8:       cur_op = 6'h0F;
      9:       cur_op = 6'h04;
      10:      cur_op = 6'h05;
      11:      cur_op = 6'h02;
      12:      cur_op = 6'h3F;
      13:      cur_op = 6'($urandom);
      14:      cur_op = 6'h00;
      default: begin cur_op = 6'h00; cur_fn = 6'h18; end
    endcase
  endtask

  // Reset dropped between edges: outputs must fall without a clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("async_reset_hold0", act0, expect_obs(blank(), z));
    check("async_reset_hold1", act1, expect_obs(blank(), z));
    trace.delete();
    stuck = 1'b0;
    @(negedge clk);
    check("reset_state0", act0, expect_obs(blank(), z));
    check("reset_state1", act1, expect_obs(blank(), z));
    reset = 1'b1;
    first_fetch = 1'b1;
  endtask

  initial begin
    step_t exp;

    trace.delete(); build_trace(6'h23, 6'h00);
    check_int("model_lw_len", trace.size(), 5);
    check_int("model_lw_wb", trace[4].memtoreg, 1);
    trace.delete(); build_trace(6'h2B, 6'h00);
    check_int("model_sw_len", trace.size(), 4);
    check_int("model_sw_memw", trace[3].memw, 1);
    trace.delete(); build_trace(6'h00, 6'h22);
    check_int("model_sub_alu", trace[2].alu, 4);
    trace.delete(); build_trace(6'h0D, 6'h00);
    check_int("model_ori_alu", trace[2].alu, 1);
    check_int("model_ori_ext", trace[2].ext, 1);
    trace.delete(); build_trace(6'h04, 6'h00);
    check_int("model_beq_len", trace.size(), 3);
    trace.delete(); build_trace(6'h00, 6'h18);
    check_int("model_badfn_len", trace.size(), 3);
    check_int("model_badfn_ill", trace[2].illegal, 1);
    trace.delete();

    z = 1'b0;
    drive(6'h00, 6'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_initial0", act0, expect_obs(blank(), z));
    check("reset_initial1", act1, expect_obs(blank(), z));
    reset = 1'b1;
    first_fetch = 1'b1;
    stuck = 1'b0;
    lw_reset_done = 1'b0;
    step = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (trace.size() == 0) begin
        pick_instr();
        build_trace(cur_op, cur_fn);
        step = 0;
      end
      z = 1'($urandom);
      drive(cur_op, cur_fn, z);
      @(negedge clk);
      exp = trace.pop_front();
      step++;
      check("dut_hold0", act0, expect_obs(exp, z));
      check("dut_hold1", act1, stuck ? expect_obs(blank() | step_t'(1), z) : expect_obs(exp, z));
      if (exp.illegal) stuck = 1'b1;
      if (first_fetch) begin
        check_int("first_fetch_irwrite", bus0.IRWrite, 1);
        check_int("first_fetch_pcen", bus0.PCEn, 1);
        check_int("first_fetch_aluop", bus0.ALUOperation, 3);
        first_fetch = 1'b0;
      end
      if (!lw_reset_done && cur_op == 6'h23 && step == 4) begin
        lw_reset_done = 1'b1;
        do_reset();
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
    end
    check_int("lw_memrd_reset_seen", int'(lw_reset_done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
